// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one shared single-cycle memory; optional MEM_ARBITER_RR_EN selects round-robin over fixed data priority.
// Latency: request seen in IDLE -> ISSUE next cycle -> ack the cycle after; one access per 3 cycles.
// Backpressure: requesters hold req until their ack pulse; the loser simply stays pending.
module mem_arbiter #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_req,
    input  logic [n-1:0] i_addr,
    output logic         i_ack,
    output logic [n-1:0] i_rdata,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [n-1:0] d_addr,
    input  logic [n-1:0] d_wdata,
    output logic         d_ack,
    output logic [n-1:0] d_rdata,
    output logic         mem_en,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    input  logic [n-1:0] mem_rdata,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef enum logic [1:0] {NONE, INST, DATA} grant_t;

    state_t state, state_nxt;
    grant_t grant, grant_nxt;
    grant_t contend_pick;

`ifdef MEM_ARBITER_RR_EN
    grant_t last_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= INST;
        end else if (state == IDLE && state_nxt == ISSUE) begin
            last_grant <= grant_nxt;
        end
    end

    assign contend_pick = (last_grant == INST) ? DATA : INST;
`else
    assign contend_pick = DATA;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant <= NONE;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    state_nxt = ISSUE;
                    grant_nxt = contend_pick;
                end else if (d_req) begin
                    state_nxt = ISSUE;
                    grant_nxt = DATA;
                end else if (i_req) begin
                    state_nxt = ISSUE;
                    grant_nxt = INST;
                end
            end
            ISSUE: state_nxt = RESP;
            // Completion is unconditional so a dropped req still gets its ack.
            RESP: begin
                state_nxt = IDLE;
                grant_nxt = NONE;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = NONE;
            end
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_ack     = 1'b0;
        i_rdata   = '0;
        d_ack     = 1'b0;
        d_rdata   = '0;
        busy      = (state != IDLE);
        if (state == ISSUE) begin
            mem_en = 1'b1;
            if (grant == DATA) begin
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end else begin
                mem_addr  = i_addr;
            end
        end else if (state == RESP) begin
            if (grant == DATA) begin
                d_ack   = 1'b1;
                d_rdata = mem_rdata;
            end else if (grant == INST) begin
                i_ack   = 1'b1;
                i_rdata = mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-cycle memory and a protocol monitor.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_ack, d_ack, mem_en, mem_we, busy;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic [15:0] mem [0:255];

    int errors = 0;
    int checks = 0;
    bit mon_on = 1'b0;
    logic prev_en = 1'b0;

    mem_arbiter #(.n(16)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory: read data appears the cycle after the address is issued.
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) mem[mem_addr[7:0]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            if (i_ack === 1'b1 && d_ack === 1'b1) begin
                errors++;
                $display("FAIL mon_dual_ack: i_ack=%b d_ack=%b required not both 1", i_ack, d_ack);
            end
            checks++;
            if (mem_en === 1'b1 && (busy !== 1'b1 || i_ack === 1'b1 || d_ack === 1'b1 || prev_en === 1'b1)) begin
                errors++;
                $display("FAIL mon_en_issue_only: mem_en=1 busy=%b i_ack=%b d_ack=%b prev_en=%b", busy, i_ack, d_ack, prev_en);
            end
            prev_en = mem_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0;
    endtask

    task automatic do_reset();
        mon_on = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        prev_en = 1'b0;
        mon_on = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        checks++;
        if ({i_ack, d_ack, mem_en, mem_we, busy} !== 5'b0 ||
            {i_rdata, d_rdata, mem_addr, mem_wdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: acks/en/we/busy=%b buses=%h required all 0",
                     {i_ack, d_ack, mem_en, mem_we, busy}, {i_rdata, d_rdata, mem_addr, mem_wdata});
        end
    endtask

    task automatic test_single_fetch();
        i_req = 1; i_addr = 16'h0004;
        tick();
        checks++;
        if (mem_en !== 1 || mem_we !== 0 || mem_addr !== 16'h0004 || busy !== 1 || i_ack !== 0) begin
            errors++;
            $display("FAIL fetch_issue: en=%b we=%b addr=%h busy=%b ack=%b required 1 0 0004 1 0",
                     mem_en, mem_we, mem_addr, busy, i_ack);
        end
        tick();
        checks++;
        if (i_ack !== 1 || i_rdata !== 16'h1234 || mem_en !== 0 || mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL fetch_ack: ack=%b rdata=%h en=%b addr=%h required 1 1234 0 0000",
                     i_ack, i_rdata, mem_en, mem_addr);
        end
        i_req = 0;
        tick();
        checks++;
        if (busy !== 0 || i_ack !== 0 || i_rdata !== 16'h0) begin
            errors++;
            $display("FAIL fetch_done: busy=%b ack=%b rdata=%h required 0 0 0000", busy, i_ack, i_rdata);
        end
    endtask

    task automatic test_store_load();
        int we_cycles;
        d_req = 1; d_we = 1; d_addr = 16'h0010; d_wdata = 16'hBEEF;
        we_cycles = 0;
        tick();
        checks++;
        if (mem_en !== 1 || mem_we !== 1 || mem_addr !== 16'h0010 || mem_wdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL store_issue: en=%b we=%b addr=%h wdata=%h required 1 1 0010 beef",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        if (mem_we === 1'b1) we_cycles++;
        tick();
        if (mem_we === 1'b1) we_cycles++;
        checks++;
        if (d_ack !== 1 || mem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL store_ack: d_ack=%b mem_wdata=%h required 1 0000", d_ack, mem_wdata);
        end
        d_req = 0; d_we = 0;
        tick();
        if (mem_we === 1'b1) we_cycles++;
        checks++;
        if (we_cycles != 1) begin
            errors++;
            $display("FAIL store_we_width: mem_we cycles=%0d required 1", we_cycles);
        end
        d_req = 1; d_we = 0; d_addr = 16'h0010; d_wdata = 16'h5555;
        tick();
        checks++;
        if (mem_en !== 1 || mem_we !== 0 || mem_wdata !== 16'h5555) begin
            errors++;
            $display("FAIL load_issue: en=%b we=%b wdata=%h required 1 0 5555", mem_en, mem_we, mem_wdata);
        end
        tick();
        checks++;
        if (d_ack !== 1 || d_rdata !== 16'hBEEF || i_ack !== 0) begin
            errors++;
            $display("FAIL load_ack: d_ack=%b d_rdata=%h i_ack=%b required 1 beef 0", d_ack, d_rdata, i_ack);
        end
        d_req = 0;
        tick();
    endtask

    task automatic test_contention();
        int n_ack;
        logic [3:0] who;      // 1 = DATA, 0 = INST, in ack order
        int at [0:3];
        logic [3:0] exp_who;
        logic [15:0] rd;
`ifdef MEM_ARBITER_RR_EN
        exp_who = 4'b0101;    // bit0 first: DATA, INST, DATA, INST
`else
        exp_who = 4'b1111;
`endif
        idle_inputs();
        do_reset();
        i_req = 1; i_addr = 16'h0030;
        d_req = 1; d_we = 0; d_addr = 16'h0020;
        n_ack = 0; who = 4'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if ((i_ack === 1'b1 || d_ack === 1'b1) && n_ack < 4) begin
                who[n_ack] = d_ack;
                at[n_ack] = c;
                rd = d_ack ? d_rdata : i_rdata;
                checks++;
                if (rd !== (d_ack ? 16'hD0D0 : 16'hA1A1)) begin
                    errors++;
                    $display("FAIL contend_rdata%0d: got %h required %h", n_ack, rd, d_ack ? 16'hD0D0 : 16'hA1A1);
                end
                n_ack++;
            end
        end
        checks++;
        if (n_ack != 4) begin
            errors++;
            $display("FAIL contend_count: acks=%0d required 4", n_ack);
        end
        checks++;
        if (who !== exp_who) begin
            errors++;
            $display("FAIL contend_order: order bits=%b required %b", who, exp_who);
        end
        for (int k = 0; k < n_ack; k++) begin
            checks++;
            if (at[k] != 2 + 3 * k) begin
                errors++;
                $display("FAIL contend_timing%0d: ack cycle=%0d required %0d", k, at[k], 2 + 3 * k);
            end
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_dropped_req();
        d_req = 1; d_we = 0; d_addr = 16'h0010;
        tick();
        d_req = 0;
        checks++;
        if (mem_en !== 1 || mem_addr !== 16'h0010) begin
            errors++;
            $display("FAIL drop_issue: en=%b addr=%h required 1 0010", mem_en, mem_addr);
        end
        tick();
        checks++;
        if (d_ack !== 1 || d_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL drop_ack: d_ack=%b d_rdata=%h required 1 beef", d_ack, d_rdata);
        end
        tick();
        checks++;
        if (busy !== 0) begin
            errors++;
            $display("FAIL drop_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid_op();
        int acks;
        d_req = 1; d_we = 1; d_addr = 16'h0040; d_wdata = 16'hAAAA;
        tick();
        checks++;
        if (mem_we !== 1) begin
            errors++;
            $display("FAIL midrst_issue: mem_we=%b required 1", mem_we);
        end
        mon_on = 1'b0;
        reset = 1; d_req = 0; d_we = 0;
        tick();
        reset = 0;
        prev_en = 1'b0;
        mon_on = 1'b1;
        checks++;
        if (mem_we !== 0 || mem_en !== 0 || d_ack !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL midrst_after: we=%b en=%b d_ack=%b busy=%b required 0 0 0 0",
                     mem_we, mem_en, d_ack, busy);
        end
        acks = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (d_ack === 1'b1 || i_ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL midrst_no_ack: acks=%0d required 0", acks);
        end
        i_req = 1; i_addr = 16'h0004;
        tick();
        checks++;
        if (mem_en !== 1 || mem_addr !== 16'h0004) begin
            errors++;
            $display("FAIL midrst_next_issue: en=%b addr=%h required 1 0004", mem_en, mem_addr);
        end
        tick();
        checks++;
        if (i_ack !== 1 || i_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL midrst_next_ack: ack=%b rdata=%h required 1 1234", i_ack, i_rdata);
        end
        i_req = 0;
        tick();
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'h0;
        mem[8'h04] = 16'h1234;
        mem[8'h20] = 16'hD0D0;
        mem[8'h30] = 16'hA1A1;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_store_load();
        test_dropped_req();
        test_reset_mid_op();
        test_contention();
        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: n, default 16, address and data word width in bits.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: i_req  input  1  instruction-fetch request; held high until i_ack.
REQ-005 Port: i_addr  input  n  fetch byte address; stable while i_req is high.
REQ-006 Port: i_ack  output  1  one-cycle pulse marking fetch completion.
REQ-007 Port: i_rdata  output  n  fetched word; valid only while i_ack is high.
REQ-008 Port: d_req  input  1  data request; held high until d_ack.
REQ-009 Port: d_we  input  1  data write enable (1 = store, 0 = load); stable while d_req is high.
REQ-010 Port: d_addr  input  n  data address; stable while d_req is high.
REQ-011 Port: d_wdata  input  n  store data; stable while d_req is high.
REQ-012 Port: d_ack  output  1  one-cycle pulse marking data completion.
REQ-013 Port: d_rdata  output  n  load data; valid only while d_ack is high.
REQ-014 Port: mem_en  output  1  shared memory access strobe.
REQ-015 Port: mem_we  output  1  shared memory write enable.
REQ-016 Port: mem_addr  output  n  shared memory address.
REQ-017 Port: mem_wdata  output  n  shared memory write data.
REQ-018 Port: mem_rdata  input  n  shared memory read data; valid the cycle after the address is issued.
REQ-019 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-020 The state machine SHALL have exactly three states: IDLE, ISSUE and RESP, held in a registered grant (NONE, INST or DATA).
REQ-021 IDLE: when no request is pending, the block SHALL stay in IDLE. When at least one request is pending, it SHALL register the winner as the grant and move to ISSUE.
REQ-022 Priority when i_req and d_req are high together in IDLE: the arbitration policy is set by REQ-033/REQ-034.
REQ-023 ISSUE SHALL last one cycle and SHALL drive the following:
- mem_en = 1.
- mem_addr = address of the granted port.
- mem_we = d_we for a DATA grant, 0 for an INST grant.
- mem_wdata = d_wdata for a DATA grant.
The block SHALL then move to RESP.
REQ-024 RESP SHALL last one cycle and SHALL drive the following:
- The granted port's ack = 1.
- The granted port's rdata = mem_rdata (a store also acks; its d_rdata is don't-care).
The block SHALL then return to IDLE unconditionally.
REQ-025 Latency: a request sampled at edge k SHALL issue during cycle k+1 and SHALL ack during cycle k+2. Throughput is one access per 3 cycles.
REQ-026 Outside ISSUE, mem_en and mem_we SHALL be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-027 Outside RESP, both acks SHALL be 0, and i_rdata and d_rdata SHALL be 0.
REQ-028 i_ack and d_ack SHALL never be high in the same cycle; at most one grant is outstanding.
REQ-029 If a requester drops req after being granted (a protocol violation), the access SHALL still complete and the ack SHALL still pulse.
REQ-030 The losing request SHALL stay pending, without any latching, and SHALL be considered again in the next IDLE.

Reset
REQ-031 When reset is high at an edge, the block SHALL enter IDLE and clear the grant to NONE, and SHALL set last_grant = INST. This overrides every other transition, including mid-ISSUE and mid-RESP.
REQ-032 From the cycle after a reset edge, all outputs SHALL be 0: i_ack, d_ack, mem_en, mem_we, busy, and all data/address buses. An interrupted access SHALL never be acked.

Configuration
REQ-033 With macro MEM_ARBITER_RR_EN defined, arbitration SHALL be round-robin:
- On contention, grant the port opposite to last_grant.
- last_grant updates on every IDLE->ISSUE transition.
REQ-034 Without MEM_ARBITER_RR_EN, arbitration SHALL be fixed priority: DATA always wins contention, and the last_grant register SHALL be absent. Fetch starvation under continuous d_req is accepted.

Verification
REQ-035 Single fetch: reset, then i_req=1 with i_addr=0x0004, memory word 0x1234 -> mem_en=1 with mem_addr=0x0004 in cycle 1, then i_ack=1 with i_rdata=0x1234 in cycle 2, then busy=0.
REQ-036 Store then load: d_req store to addr 0x0010 with data 0xBEEF -> mem_we=1 for exactly one cycle, then d_ack. A load from 0x0010 then acks with d_rdata=0xBEEF.
REQ-037 Contention without the macro: i_req and d_req both high for 4 consecutive transactions -> all 4 go to DATA, i_ack never pulses.
REQ-038 Contention with MEM_ARBITER_RR_EN, both requests high continuously from reset -> ack order is DATA, INST, DATA, INST, with each ack 3 cycles apart.
REQ-039 Reset mid-operation: assert reset during ISSUE of a store -> the following cycle has mem_we=0 and no ack, and the next request completes normally with 2-cycle latency.
REQ-040 A checker SHALL confirm throughout all of the above tests:
- i_ack and d_ack are never high together.
- mem_en is high only in ISSUE.
